pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single physical-memory (L2) port between the instruction-cache miss path and the data-cache miss path.
- The instruction-cache miss path feeds the fetch unit's imem_rdata/imem_resp.
- Registered FSM with round-robin on simultaneous requests.
- One line transaction outstanding at a time.
- Address/op/write-data captured at grant, so the downstream port sees stable values for the whole transaction.

Parameters:
ADDR_W, 16, physical address width (lc3b_word).
LINE_W, 128, cache line width in bits (lc3b_line).

Ports:
clk  input  1  system clock.
rst  input  1  reset, synchronous, active-high.
i_pmem_read  input  1  I-cache line read request.
i_pmem_address  input  ADDR_W  I-cache line address.
i_pmem_rdata  output  LINE_W  line data to I-cache.
i_pmem_resp  output  1  I-cache transaction complete.
d_pmem_read  input  1  D-cache line read request.
d_pmem_write  input  1  D-cache line writeback request.
d_pmem_address  input  ADDR_W  D-cache line address.
d_pmem_wdata  input  LINE_W  D-cache writeback data.
d_pmem_rdata  output  LINE_W  line data to D-cache.
d_pmem_resp  output  1  D-cache transaction complete.
pmem_read  output  1  downstream read strobe.
pmem_write  output  1  downstream write strobe.
pmem_address  output  ADDR_W  downstream address.
pmem_wdata  output  LINE_W  downstream write data.
pmem_rdata  input  LINE_W  downstream read data.
pmem_resp  input  1  downstream completion, one-cycle pulse.
grant_i  output  1  state is SERVE_I (debug/perf).
grant_d  output  1  state is SERVE_D (debug/perf).

Behaviour:
- Reset:
  - state=IDLE, last_grant=D, latched address/wdata/op = 0.
  - pmem_read, pmem_write, grant_*, *_resp all 0.
  - rst takes priority over every other event, including mid-transaction.
  - After reset mid-transaction, a late pmem_resp arriving in IDLE is ignored and not forwarded.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - req_i = i_pmem_read; req_d = d_pmem_read | d_pmem_write.
  - Only req_i: next SERVE_I. Only req_d: next SERVE_D.
  - Both: grant the side != last_grant (first tie after reset goes to I).
  - On the grant edge: latch the requester's address, d_pmem_wdata (D only) and op (I is always read; D write has precedence if read and write are both high); update last_grant.
  - Neither: stay IDLE.
- SERVE_x:
  - pmem_read/pmem_write driven from the latched op; pmem_address/pmem_wdata from latched registers.
  - Request latency to downstream: one cycle after the request is seen in IDLE.
  - Holds until pmem_resp=1. In that cycle x_pmem_resp=1 combinationally and next state=IDLE.
  - pmem_read/pmem_write drop the cycle after resp.
- Return and turnaround:
  - A requester seeing resp deasserts on the next edge, so IDLE never re-grants a stale request.
  - Minimum gap between back-to-back transactions: one IDLE cycle.
- Read data:
  - i_pmem_rdata and d_pmem_rdata are always equal to pmem_rdata (pass-through).
  - Only the granted side's resp is ever asserted; the other side's resp is 0.
- Requester deasserting mid-service: ignored; the transaction completes and resp is still pulsed.
- Latched address/wdata do not change during SERVE even if requester inputs change.
- No timeout. Waiting indefinitely for pmem_resp is legal.

Decomposition:
- lc3b_types supplies lc3b_word and lc3b_line.
- Add to the shared package: enum arb_state_t {IDLE, SERVE_I, SERVE_D} and enum arb_src_t {SRC_I, SRC_D}.
- One natural sub-module: arb_rr2, the 2-way round-robin picker holding last_grant (req_i, req_d, advance → pick).
- Latch registers use the existing register module.

Test Plan:
- I-only: i_pmem_read=1, addr 0x1230 at cycle 0; memory resps at cycle 4 with 0xDEAD..BEEF.
  - pmem_read=1, address=0x1230 from cycle 1; i_pmem_resp=1 at cycle 4 with that rdata.
  - d_pmem_resp=0 throughout; IDLE at cycle 5.
- D writeback: d_pmem_write=1, addr 0x4000, wdata 0x0123…CDEF.
  - pmem_write=1, pmem_wdata exact, pmem_read=0.
  - d_pmem_resp pulses once; wdata stays stable even if the input is changed mid-service.
- Tie after reset: I (0x1000) and D read (0x2000) asserted together.
  - I served first; D served starting one IDLE cycle after I's resp.
  - A second simultaneous tie then goes to I again, because last_grant=D.
- Read+write both high on D: pmem_write=1, pmem_read=0.
- Reset mid-SERVE_D: rst at cycle 3, then pmem_resp at cycle 5 → d_pmem_resp stays 0, state IDLE, strobes 0 from cycle 4.
- Requester drop: I deasserts i_pmem_read mid-service → pmem_read stays 1 until resp; i_pmem_resp still pulses once.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the L2 port arbiter: LC-3b word/line types and arbiter enums.
// Latency: n/a (types only).
// Backpressure: n/a.
package pmem_arbiter_pkg;

    localparam int LC3B_ADDR_W = 16;
    localparam int LC3B_LINE_W = 128;

    typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; remembers the last granted side.
// Latency: pick is combinational, history updates on the advance edge.
// Backpressure: none; pick is only meaningful when a request is present.
module arb_rr2
    import pmem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     req_icache_i,
    input  logic     req_dcache_i,
    input  logic     advance_i,
    output arb_src_t pick_o
);

    arb_src_t last_grant_q;

    always_comb begin
        pick_o = SRC_D;
        if (req_icache_i && req_dcache_i) begin
            pick_o = (last_grant_q == SRC_D) ? SRC_I : SRC_D;
        end else if (req_icache_i) begin
            pick_o = SRC_I;
        end
    end

    // Resetting to D makes the first tie after reset go to the I side.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= SRC_D;
        end else if (advance_i) begin
            last_grant_q <= pick_o;
        end
    end

endmodule

// File: rtl/register.sv
// Loadable register with synchronous active-high clear.
// Latency: one cycle from load to q.
// Backpressure: none; holds value while load is low.
module register #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the L2 port between I-cache and D-cache miss paths, one line at a time.
// Latency: downstream strobe one cycle after a request is seen in IDLE.
// Backpressure: requests wait in IDLE/SERVE until pmem_resp; no timeout.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = LC3B_ADDR_W,
    parameter int LINE_W = LC3B_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              grant_i,
    output logic              grant_d
);

    arb_state_t        state_q;
    arb_src_t          pick;
    logic              req_i;
    logic              req_d;
    logic              grant;
    logic [ADDR_W-1:0] addr_d;
    logic              op_wr_d;
    logic              op_wr_q;

    assign req_i = i_pmem_read;
    assign req_d = d_pmem_read | d_pmem_write;
    assign grant = (state_q == IDLE) && (req_i || req_d);

    arb_rr2 u_rr (
        .clk          (clk),
        .rst          (rst),
        .req_icache_i (req_i),
        .req_dcache_i (req_d),
        .advance_i    (grant),
        .pick_o       (pick)
    );

    // Writeback wins over a simultaneous read on the D side.
    assign addr_d  = (pick == SRC_I) ? i_pmem_address : d_pmem_address;
    assign op_wr_d = (pick == SRC_D) && d_pmem_write;

    register #(.W(ADDR_W)) u_addr_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (grant),
        .d_i    (addr_d),
        .q_o    (pmem_address)
    );

    register #(.W(LINE_W)) u_wdata_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (grant && (pick == SRC_D)),
        .d_i    (d_pmem_wdata),
        .q_o    (pmem_wdata)
    );

    register #(.W(1)) u_op_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (grant),
        .d_i    (op_wr_d),
        .q_o    (op_wr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= (pick == SRC_I) ? SERVE_I : SERVE_D;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Everything downstream decodes from registered state and latched op only.
    assign grant_i     = (state_q == SERVE_I);
    assign grant_d     = (state_q == SERVE_D);
    assign pmem_read   = (grant_i | grant_d) & ~op_wr_q;
    assign pmem_write  = (grant_i | grant_d) & op_wr_q;
    assign i_pmem_resp = grant_i & pmem_resp;
    assign d_pmem_resp = grant_d & pmem_resp;

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: table-driven transactions plus tie and reset sequences.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         grant_i;
    logic         grant_d;

    int checks = 0;
    int failures = 0;

    pmem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .grant_i        (grant_i),
        .grant_d        (grant_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_d;
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int           lat;
        logic         drop;
        logic         exp_rd;
        logic         exp_wr;
    } vec_t;

    typedef struct {
        logic         is_d;
        logic [15:0]  addr;
        logic         rd;
        logic         wr;
        logic [127:0] wdata;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_rdata     = '0;
        pmem_resp      = 1'b0;
    endtask

    // Acts as the memory side: waits for a strobe, checks it against the scoreboard,
    // holds for lat cycles while the requester scribbles on its inputs, then responds.
    task automatic serve_one(input int exp_wait, input logic [127:0] rdata, input int lat, input logic drop);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!(pmem_read || pmem_write) && w < 20) begin
            next_cycle();
            @(negedge clk);
            w++;
        end
        chkv("grant_latency", 128'(w), 128'(exp_wait));
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
            return;
        end
        e = sb.pop_front();
        if (w >= 20) return;
        chkv("addr", 128'(pmem_address), 128'(e.addr));
        chkb("pmem_read", pmem_read, e.rd);
        chkb("pmem_write", pmem_write, e.wr);
        chkb("grant_i", grant_i, !e.is_d);
        chkb("grant_d", grant_d, e.is_d);
        if (e.wr) chkv("wdata", pmem_wdata, e.wdata);
        for (int k = 0; k < lat; k++) begin
            next_cycle();
            if (drop) begin
                if (e.is_d) begin
                    d_pmem_read  = 1'b0;
                    d_pmem_write = 1'b0;
                end else begin
                    i_pmem_read = 1'b0;
                end
            end else if (e.is_d) begin
                d_pmem_address = 16'($urandom);
                d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                i_pmem_address = 16'($urandom);
            end
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chkv("hold_addr", 128'(pmem_address), 128'(e.addr));
            chkb("hold_read", pmem_read, e.rd);
            chkb("hold_write", pmem_write, e.wr);
            chkb("hold_i_resp", i_pmem_resp, 1'b0);
            chkb("hold_d_resp", d_pmem_resp, 1'b0);
            chkv("passthru_i", i_pmem_rdata, pmem_rdata);
            if (e.wr) chkv("hold_wdata", pmem_wdata, e.wdata);
        end
        next_cycle();
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
        @(negedge clk);
        chkb("i_resp", i_pmem_resp, !e.is_d);
        chkb("d_resp", d_pmem_resp, e.is_d);
        chkv("i_rdata", i_pmem_rdata, rdata);
        chkv("d_rdata", d_pmem_rdata, rdata);
        next_cycle();
        pmem_resp = 1'b0;
        if (e.is_d) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end else begin
            i_pmem_read = 1'b0;
        end
        @(negedge clk);
        chkb("gap_read", pmem_read, 1'b0);
        chkb("gap_write", pmem_write, 1'b0);
        chkb("gap_i_resp", i_pmem_resp, 1'b0);
        chkb("gap_d_resp", d_pmem_resp, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h1230, 128'h0, 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF, 2, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h4000, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 128'h0, 3, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h2222, 128'h5555, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h3330, 128'hA5A5_0000_FFFF_1234_A5A5_0000_FFFF_1234, 128'h0, 2, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'hFFFE, 128'h0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 3, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0010, 128'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        clear_inputs();
        next_cycle();
        @(negedge clk);
        chkb("rst_read", pmem_read, 1'b0);
        chkb("rst_write", pmem_write, 1'b0);
        chkb("rst_grant_i", grant_i, 1'b0);
        chkb("rst_grant_d", grant_d, 1'b0);
        chkb("rst_i_resp", i_pmem_resp, 1'b0);
        chkb("rst_d_resp", d_pmem_resp, 1'b0);
        chkv("rst_addr", 128'(pmem_address), 128'h0);
        chkv("rst_wdata", pmem_wdata, 128'h0);
        next_cycle();
        rst = 1'b0;

        foreach (vecs[i]) begin
            next_cycle();
            if (vecs[i].is_d) begin
                d_pmem_read    = vecs[i].rd;
                d_pmem_write   = vecs[i].wr;
                d_pmem_address = vecs[i].addr;
                d_pmem_wdata   = vecs[i].wdata;
            end else begin
                i_pmem_read    = vecs[i].rd;
                i_pmem_address = vecs[i].addr;
            end
            sb.push_back('{vecs[i].is_d, vecs[i].addr, vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].wdata});
            serve_one(1, vecs[i].rdata, vecs[i].lat, vecs[i].drop);
        end

        // Reset while serving D; a late response must not be forwarded.
        next_cycle();
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h5550;
        @(negedge clk);
        chkb("mid_c0_grant_d", grant_d, 1'b0);
        next_cycle();
        @(negedge clk);
        chkb("mid_c1_read", pmem_read, 1'b1);
        chkb("mid_c1_grant_d", grant_d, 1'b1);
        chkv("mid_c1_addr", 128'(pmem_address), 128'h5550);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        d_pmem_read = 1'b0;
        @(negedge clk);
        chkb("mid_c3_read", pmem_read, 1'b1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chkb("mid_c4_read", pmem_read, 1'b0);
        chkb("mid_c4_write", pmem_write, 1'b0);
        chkb("mid_c4_grant_d", grant_d, 1'b0);
        chkv("mid_c4_addr", 128'(pmem_address), 128'h0);
        next_cycle();
        pmem_resp  = 1'b1;
        pmem_rdata = 128'h7777;
        @(negedge clk);
        chkb("late_d_resp", d_pmem_resp, 1'b0);
        chkb("late_i_resp", i_pmem_resp, 1'b0);
        next_cycle();
        pmem_resp = 1'b0;
        @(negedge clk);
        chkb("late_grant_i", grant_i, 1'b0);
        chkb("late_grant_d", grant_d, 1'b0);
        chkb("late_read", pmem_read, 1'b0);

        // Two ties after reset: both should go to I first, D one IDLE cycle later.
        for (int t = 0; t < 2; t++) begin
            next_cycle();
            i_pmem_read    = 1'b1;
            i_pmem_address = 16'h1000;
            d_pmem_read    = 1'b1;
            d_pmem_address = 16'h2000;
            sb.push_back('{1'b0, 16'h1000, 1'b1, 1'b0, 128'h0});
            sb.push_back('{1'b1, 16'h2000, 1'b1, 1'b0, 128'h0});
            serve_one(1, 128'h0A0A_0000_0000_0000_0000_0000_0000_0001, 1, 1'b0);
            serve_one(0, 128'h0B0B_0000_0000_0000_0000_0000_0000_0002, 1, 1'b0);
        end

        chkv("sb_drained", 128'(sb.size()), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
